// File: rtl/regfile_access_sequencer.sv
// Sequences one operand-fetch / write-back request against an asynchronous
// 32x32 register-file RAM and returns the rs1/rs2 operands over valid/ready.
module regfile_access_sequencer #(
  parameter int READ_WAIT = 2,
  parameter int WR_PULSE  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [4:0]  ram_write_addr,
  output logic [31:0] ram_d_write,
  output logic        ram_nWR,
  output logic [4:0]  ram_read_addr,
  output logic        ram_nOE,
  input  logic [31:0] ram_d_read,
  output logic [2:0]  dbg_state
);

  // Handshakes: a request transfers on the rising edge where req_valid and
  // req_ready are both 1; a response transfers where rsp_valid and rsp_ready
  // are both 1. Neither side may retract valid before its transfer.

  // Debug encoding is part of the visible interface: IDLE is always 0.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_SETUP = 3'd1,
    S_WR_PULSE = 3'd2,
    S_WR_HOLD  = 3'd3,
    S_RD1      = 3'd4,
    S_RD2      = 3'd5,
    S_RESP     = 3'd6
  } state_t;

  localparam int CNT_MAX = (READ_WAIT > WR_PULSE) ? READ_WAIT : WR_PULSE;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [31:0]       r_rs1_data;
  logic [31:0]       r_rs2_data;
  logic              r_nwr;
  logic              r_noe;
  logic [4:0]        r_read_addr;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [4:0]        r_write_addr;
  logic [31:0]       r_d_write;

  logic w_accept;
  logic w_do_write;
  logic w_cnt_done;

  assign w_accept   = req_valid && r_req_ready;
  assign w_do_write = wr_en && (rd != 5'd0);
  assign w_cnt_done = (r_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rs1_data  <= 32'd0;
      r_rs2_data  <= 32'd0;
      r_nwr       <= 1'b1;
      r_noe       <= 1'b1;
      r_read_addr <= 5'd0;
      r_rs1       <= 5'd0;
      r_rs2       <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_rs1       <= rs1;
            r_rs2       <= rs2;
            r_req_ready <= 1'b0;
            if (w_do_write) begin
              r_state <= S_WR_SETUP;
            end else begin
              r_state     <= S_RD1;
              r_noe       <= 1'b0;
              r_read_addr <= rs1;
              r_cnt       <= RD_LOAD;
            end
          end
        end
        S_WR_SETUP: begin
          r_state <= S_WR_PULSE;
          r_nwr   <= 1'b0;
          r_cnt   <= WR_LOAD;
        end
        S_WR_PULSE: begin
          if (w_cnt_done) begin
            r_state <= S_WR_HOLD;
            r_nwr   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WR_HOLD: begin
          // nWR already rose last edge, so nOE falling here never overlaps it.
          r_state     <= S_RD1;
          r_noe       <= 1'b0;
          r_read_addr <= r_rs1;
          r_cnt       <= RD_LOAD;
        end
        S_RD1: begin
          if (w_cnt_done) begin
            r_rs1_data  <= (r_rs1 == 5'd0) ? 32'd0 : ram_d_read;
            r_state     <= S_RD2;
            r_read_addr <= r_rs2;
            r_cnt       <= RD_LOAD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RD2: begin
          if (w_cnt_done) begin
            r_rs2_data  <= (r_rs2 == 5'd0) ? 32'd0 : ram_d_read;
            r_noe       <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_nwr       <= 1'b1;
          r_noe       <= 1'b1;
        end
      endcase
    end
  end

  // Write address/data deliberately have no reset: a reset that cuts a
  // write pulse short must leave them pointing at the intended entry.
  always_ff @(posedge clk) begin
    if (!reset && (r_state == S_IDLE) && w_accept && w_do_write) begin
      r_write_addr <= rd;
      r_d_write    <= wr_data;
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rs1_data       = r_rs1_data;
  assign rs2_data       = r_rs2_data;
  assign ram_write_addr = r_write_addr;
  assign ram_d_write    = r_d_write;
  assign ram_nWR        = r_nwr;
  assign ram_read_addr  = r_read_addr;
  assign ram_nOE        = r_noe;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_regfile_access_sequencer.sv
// Bench for regfile_access_sequencer: behavioural RAM, architectural register
// model with an expected-operand queue, directed cases then random requests.
module tb_regfile_access_sequencer;

  localparam int RW   = 2;
  localparam int WP   = 2;
  localparam int RW_B = 1;
  localparam int WP_B = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;
  bit   armed = 1'b0;

  // ---------------- DUT A (default timing) ----------------
  logic        req_valid, req_ready, wr_en, rsp_valid, rsp_ready;
  logic [4:0]  rs1, rs2, rd, ram_write_addr, ram_read_addr;
  logic [31:0] wr_data, rs1_data, rs2_data, ram_d_write, ram_d_read;
  logic        ram_nWR, ram_nOE;
  logic [2:0]  dbg_state;

  regfile_access_sequencer #(.READ_WAIT(RW), .WR_PULSE(WP)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .wr_en(wr_en), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .ram_write_addr(ram_write_addr), .ram_d_write(ram_d_write),
    .ram_nWR(ram_nWR), .ram_read_addr(ram_read_addr), .ram_nOE(ram_nOE),
    .ram_d_read(ram_d_read), .dbg_state(dbg_state)
  );

  // ---------------- DUT B (READ_WAIT=1, WR_PULSE=3) ----------------
  logic        req_valid_b, req_ready_b, wr_en_b, rsp_valid_b, rsp_ready_b;
  logic [4:0]  rs1_b, rs2_b, rd_b, ram_write_addr_b, ram_read_addr_b;
  logic [31:0] wr_data_b, rs1_data_b, rs2_data_b, ram_d_write_b, ram_d_read_b;
  logic        ram_nWR_b, ram_nOE_b;
  logic [2:0]  dbg_state_b;

  regfile_access_sequencer #(.READ_WAIT(RW_B), .WR_PULSE(WP_B)) u_dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
    .rs1(rs1_b), .rs2(rs2_b), .rd(rd_b), .wr_en(wr_en_b), .wr_data(wr_data_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rs1_data(rs1_data_b),
    .rs2_data(rs2_data_b), .ram_write_addr(ram_write_addr_b), .ram_d_write(ram_d_write_b),
    .ram_nWR(ram_nWR_b), .ram_read_addr(ram_read_addr_b), .ram_nOE(ram_nOE_b),
    .ram_d_read(ram_d_read_b), .dbg_state(dbg_state_b)
  );

  // ---------------- asynchronous RAM models ----------------
  logic [31:0] ram_a [32];
  logic [31:0] ram_b [32];

  always @(posedge ram_nWR)   if (armed) ram_a[ram_write_addr]   = ram_d_write;
  always @(posedge ram_nWR_b) if (armed) ram_b[ram_write_addr_b] = ram_d_write_b;

  assign ram_d_read   = ram_nOE   ? 32'hBAD0BAD0 : ram_a[ram_read_addr];
  assign ram_d_read_b = ram_nOE_b ? 32'hBAD0BAD0 : ram_b[ram_read_addr_b];

  // ---------------- scoreboard ----------------
  logic [31:0] ref_mem [32];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Per-cycle compare against the model while out of reset.
  always @(negedge clk) begin
    if (!reset && armed) begin
      chk("noe_nwr_exclusive", 32'(!ram_nOE && !ram_nWR), 32'd0);
      chk("noe_nwr_exclusive_b", 32'(!ram_nOE_b && !ram_nWR_b), 32'd0);
      if (rsp_valid) begin
        if (exp_q.size() >= 2) begin
          chk("rsp_rs1_data", rs1_data, exp_q[0]);
          chk("rsp_rs2_data", rs2_data, exp_q[1]);
        end else begin
          chk("rsp_without_request", 32'(exp_q.size()), 32'd2);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] d,
                        input logic we, input logic [31:0] wd, input int bp,
                        output int lat, output int nw,
                        output logic [31:0] d1, output logic [31:0] d2);
    bit has_wr;
    int exp_lat, exp_w, edges;
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    rs1 = a1; rs2 = a2; rd = d; wr_en = we; wr_data = wd; req_valid = 1'b1; rsp_ready = 1'b0;
    has_wr = we && (d != 5'd0);
    if (has_wr) ref_mem[d] = wd;
    exp_q.push_back((a1 == 5'd0) ? 32'd0 : ref_mem[a1]);
    exp_q.push_back((a2 == 5'd0) ? 32'd0 : ref_mem[a2]);
    exp_lat = has_wr ? (2 + WP + 2 * RW) : (2 * RW);
    exp_w   = has_wr ? WP : 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom);
    wr_en = 1'($urandom); wr_data = $urandom;
    edges = 0; nw = 0;
    while (!rsp_valid && edges < 60) begin
      if (!ram_nWR) nw++;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (has_wr && edges <= 1 + WP) begin
        chk("wr_addr_stable", 32'(ram_write_addr), 32'(d));
        chk("wr_data_stable", ram_d_write, wd);
      end
      @(posedge clk); edges++; @(negedge clk);
    end
    lat = edges;
    d1 = rs1_data; d2 = rs2_data;
    chk("latency", 32'(edges), 32'(exp_lat));
    chk("nwr_low_width", 32'(nw), 32'(exp_w));
    chk("noe_high_in_resp", 32'(ram_nOE), 32'd1);
    repeat (bp) begin
      @(posedge clk); @(negedge clk);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      if (exp_q.size() >= 2) begin
        chk("bp_rs1_stable", rs1_data, exp_q[0]);
        chk("bp_rs2_stable", rs2_data, exp_q[1]);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    if (exp_q.size() >= 2) begin
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
    end
    chk("rsp_valid_after_hs", 32'(rsp_valid), 32'd0);
    chk("req_ready_after_hs", 32'(req_ready), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, nw, edges;
    logic [31:0] d1, d2, wd;
    logic [4:0] a1, a2, d;
    reset = 1'b0;
    req_valid = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0; wr_data = 32'd0;
    req_valid_b = 1'b0; rsp_ready_b = 1'b1; wr_en_b = 1'b0;
    rs1_b = 5'd0; rs2_b = 5'd0; rd_b = 5'd0; wr_data_b = 32'd0;
    for (int i = 0; i < 32; i++) begin
      ram_a[i] = $urandom; ref_mem[i] = ram_a[i]; ram_b[i] = $urandom;
    end
    ram_a[0] = 32'h5A5A5A5A;
    ram_a[3] = 32'h00001234; ref_mem[3] = 32'h00001234;
    ram_a[7] = 32'hFFFF0000; ref_mem[7] = 32'hFFFF0000;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rs1_data", rs1_data, 32'd0);
    chk("rst_rs2_data", rs2_data, 32'd0);
    chk("rst_nwr", 32'(ram_nWR), 32'd1);
    chk("rst_noe", 32'(ram_nOE), 32'd1);
    chk("rst_read_addr", 32'(ram_read_addr), 32'd0);
    chk("rst_dbg_state", 32'(dbg_state), 32'd0);
    chk("rst_dbg_state_b", 32'(dbg_state_b), 32'd0);
    reset = 1'b0;
    armed = 1'b1;

    // Write then read back through rs1.
    do_req(5'd5, 5'd0, 5'd5, 1'b1, 32'hDEADBEEF, 0, lat, nw, d1, d2);
    chk("pin_wr_latency", 32'(lat), 32'd8);
    chk("pin_wr_nwr_width", 32'(nw), 32'd2);
    chk("pin_wr_rs1", d1, 32'hDEADBEEF);
    chk("pin_wr_rs2", d2, 32'd0);
    chk("pin_wr_ram_x5", ram_a[5], 32'hDEADBEEF);

    // Read only from preloaded entries.
    do_req(5'd3, 5'd7, 5'd4, 1'b0, 32'h0BADF00D, 0, lat, nw, d1, d2);
    chk("pin_rd_latency", 32'(lat), 32'd4);
    chk("pin_rd_nwr_width", 32'(nw), 32'd0);
    chk("pin_rd_rs1", d1, 32'h00001234);
    chk("pin_rd_rs2", d2, 32'hFFFF0000);

    // Write to x0 is dropped, x0 reads as zero.
    do_req(5'd0, 5'd0, 5'd0, 1'b1, 32'h11111111, 0, lat, nw, d1, d2);
    chk("pin_x0_latency", 32'(lat), 32'd4);
    chk("pin_x0_nwr_width", 32'(nw), 32'd0);
    chk("pin_x0_rs1", d1, 32'd0);
    chk("pin_x0_ram_untouched", ram_a[0], 32'h5A5A5A5A);

    // Backpressure for 5 cycles.
    do_req(5'd12, 5'd3, 5'd12, 1'b1, 32'hCAFE0012, 5, lat, nw, d1, d2);
    chk("pin_bp_rs1", d1, 32'hCAFE0012);

    // Reset during the first write-pulse cycle.
    @(negedge clk);
    rs1 = 5'd9; rs2 = 5'd0; rd = 5'd9; wr_en = 1'b1; wr_data = 32'hA5A5A5A5; req_valid = 1'b1;
    ref_mem[9] = 32'hA5A5A5A5;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    edges = 0;
    while (ram_nWR && edges < 10) begin
      @(posedge clk); edges++; @(negedge clk);
    end
    chk("midwr_pulse_seen", 32'(ram_nWR), 32'd0);
    reset = 1'b1;
    #1;
    chk("midwr_nwr_rises", 32'(ram_nWR), 32'd1);
    chk("midwr_addr_held", 32'(ram_write_addr), 32'd9);
    chk("midwr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midwr_req_ready", 32'(req_ready), 32'd1);
    chk("midwr_dbg_idle", 32'(dbg_state), 32'd0);
    chk("midwr_x9", ram_a[9], 32'hA5A5A5A5);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i < 32; i++) chk($sformatf("midwr_mem_x%0d", i), ram_a[i], ref_mem[i]);
    do_req(5'd9, 5'd5, 5'd0, 1'b0, 32'd0, 1, lat, nw, d1, d2);
    chk("pin_midwr_readback", d1, 32'hA5A5A5A5);

    // Random requests.
    repeat (40) begin
      a1 = 5'($urandom_range(0, 15));
      a2 = 5'($urandom_range(0, 15));
      d  = 5'($urandom_range(0, 15));
      do_req(a1, a2, d, 1'($urandom_range(0, 1)), $urandom, int'($urandom_range(0, 3)),
             lat, nw, d1, d2);
    end
    for (int i = 1; i < 32; i++) chk($sformatf("final_mem_x%0d", i), ram_a[i], ref_mem[i]);

    // Alternate timing: rsp_ready_b stays high the whole time.
    wd = $urandom;
    @(negedge clk);
    rd_b = 5'd12; wr_en_b = 1'b1; wr_data_b = wd; rs1_b = 5'd12; rs2_b = 5'd0; req_valid_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid_b = 1'b0;
    edges = 0; nw = 0;
    while (!rsp_valid_b && edges < 60) begin
      if (!ram_nWR_b) nw++;
      @(posedge clk); edges++; @(negedge clk);
    end
    chk("b_latency_model", 32'(edges), 32'(2 + WP_B + 2 * RW_B));
    chk("b_latency", 32'(edges), 32'd7);
    chk("b_nwr_width", 32'(nw), 32'd3);
    chk("b_rs1_data", rs1_data_b, wd);
    chk("b_rs2_data", rs2_data_b, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b_rsp_valid_drop", 32'(rsp_valid_b), 32'd0);
    chk("b_req_ready_back", 32'(req_ready_b), 32'd1);
    chk("b_ram_x12", ram_b[12], wd);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_access_sequencer.md
Name: regfile_access_sequencer

Overview:
Clocked controller that sits directly upstream of the 32-entry asynchronous dual-port register-file RAM (two 16-bit chips in parallel, giving 32 bits). It accepts one operand-fetch/write-back request per instruction and sequences the RAM's address, data, active-low output-enable and active-low write strobe with fixed, parameterised cycle timing. It then returns the latched rs1/rs2 operands to the CPU core over a valid/ready handshake.

Parameters:
READ_WAIT, 2, cycles ram_nOE is held low per read before ram_d_read is sampled; must be >= 1
WR_PULSE, 2, cycles ram_nWR is held low during a write; must be >= 1

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  asynchronous, active-high
req_valid  input  1  request present
req_ready  output  1  block idle, can accept a request
rs1  input  5  first source register index
rs2  input  5  second source register index
rd  input  5  write-back register index
wr_en  input  1  perform write-back of wr_data to rd
wr_data  input  32  write-back value
rsp_valid  output  1  rs1_data/rs2_data valid
rsp_ready  input  1  consumer accepts response
rs1_data  output  32  operand 1 (0 when rs1 == 0)
rs2_data  output  32  operand 2 (0 when rs2 == 0)
ram_write_addr  output  5  RAM write address
ram_d_write  output  32  RAM write data
ram_nWR  output  1  RAM write strobe; RAM commits on rising edge
ram_read_addr  output  5  RAM read address
ram_nOE  output  1  RAM output enable, active low
ram_d_read  input  32  RAM read data

Behaviour:
- Reset (async, active-high) values:
  - state IDLE; req_ready=1; rsp_valid=0; rs1_data=rs2_data=0; ram_nWR=1; ram_nOE=1; ram_read_addr=0.
  - ram_write_addr and ram_d_write are NOT reset and hold their last value (undefined before the first write phase). A reset that raises ram_nWR mid-pulse therefore commits the intended write and never corrupts another entry.
- All outputs are driven from registers. ram_nWR and ram_nOE are glitch-free.
- Handshake:
  - Accept on the clk edge where req_valid && req_ready. rs1, rs2, rd, wr_en and wr_data are captured at that edge and later input changes are ignored.
  - req_ready=1 only in IDLE.
- States:
  - IDLE: waits for a request. On accept, goes to WR_SETUP if wr_en && rd != 0, otherwise goes to RD1. A write to x0 skips the write phase entirely and ram_nWR never falls.
  - WR_SETUP (1 cycle): ram_write_addr=rd and ram_d_write=wr_data are driven; ram_nWR=1.
  - WR_PULSE (WR_PULSE cycles): ram_nWR=0; address and data are held.
  - WR_HOLD (1 cycle): ram_nWR=1; address and data are held, covering RAM hold time.
  - RD1 (READ_WAIT cycles): ram_read_addr=rs1; ram_nOE=0. ram_d_read is sampled into rs1_data on the edge that ends RD1, or 0 is loaded if rs1 == 0.
  - RD2 (READ_WAIT cycles): same as RD1, but using rs2 and rs2_data.
  - RESP: ram_nOE=1; ram_read_addr holds rs2; rsp_valid=1. rs1_data/rs2_data are stable until rsp_valid && rsp_ready, then the block returns to IDLE. There is no accept in the RESP cycle.
- The write phase always precedes the reads, so rd == rs1 or rd == rs2 returns the newly written value. No forwarding is needed.
- Latency (edges from accept to rsp_valid=1):
  - With a write: 2 + WR_PULSE + 2*READ_WAIT (default 8).
  - Without a write: 2*READ_WAIT (default 4).
- ram_nOE and ram_nWR are never low in the same cycle.
- A single down-counter, sized to max(READ_WAIT, WR_PULSE), times WR_PULSE, RD1 and RD2. It is reloaded on each state entry.
- rsp_ready held high while rsp_valid=0 has no effect.

Test Plan:
- Write then read: reset; req wr_en=1, rd=5, wr_data=0xDEADBEEF, rs1=5, rs2=0.
  - ram_nWR is low for exactly 2 cycles with ram_write_addr=5 and ram_d_write=0xDEADBEEF stable from WR_SETUP through WR_HOLD.
  - rsp_valid rises 8 edges after accept with rs1_data=0xDEADBEEF and rs2_data=0.
- Read only: preload x3=0x00001234 and x7=0xFFFF0000; req wr_en=0, rs1=3, rs2=7.
  - rsp_valid rises after 4 edges with rs1_data=0x00001234 and rs2_data=0xFFFF0000.
  - ram_nWR stays 1 throughout.
- x0 protection: req wr_en=1, rd=0, wr_data=0x11111111, rs1=0.
  - ram_nWR never falls; latency is 4; rs1_data=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid.
  - rsp_valid, rs1_data and rs2_data remain stable and req_ready stays 0.
  - Raising rsp_ready returns the block to IDLE next edge with req_ready=1.
- Reset mid-write: assert reset during the first WR_PULSE cycle of rd=9, wr_data=0xA5A5A5A5.
  - ram_nWR rises immediately and ram_write_addr stays 9, so x9 holds 0xA5A5A5A5.
  - All other entries are unchanged.
  - The block is in IDLE with rsp_valid=0.
- Parameter sweep: READ_WAIT=1, WR_PULSE=3.
  - The write-plus-read latency is 7 and the nWR low width is 3 cycles.
